// File: rtl/wb_arbiter_n_pkg.sv
// Shared types and policy constants for the N-master Wishbone arbiter.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

endpackage

// File: rtl/wb_arbiter_n_if.sv
// Bundle of master-side and slave-side Wishbone pipelined signals around the arbiter.
interface wb_arbiter_n_if #(
   parameter int NMASTER = 2,
   parameter int AWIDTH  = 32,
   parameter int DWIDTH  = 32
);
   // Handshake: a strobe is accepted in a cycle where stb is high and stall is low;
   // each accepted strobe is answered by exactly one ack, possibly cycles later.
   logic [NMASTER-1:0]          m_cyc_i;
   logic [NMASTER-1:0]          m_stb_i;
   logic [NMASTER-1:0]          m_we_i;
   logic [NMASTER*AWIDTH-1:0]   m_adr_i;
   logic [NMASTER*DWIDTH/8-1:0] m_sel_i;
   logic [NMASTER*DWIDTH-1:0]   m_dat_i;
   logic [DWIDTH-1:0]           m_dat_o;
   logic [NMASTER-1:0]          m_ack_o;
   logic [NMASTER-1:0]          m_stall_o;

   logic                        cyc_o;
   logic                        stb_o;
   logic                        we_o;
   logic [AWIDTH-1:0]           adr_o;
   logic [DWIDTH/8-1:0]         sel_o;
   logic [DWIDTH-1:0]           dat_o;
   logic [DWIDTH-1:0]           dat_i;
   logic                        ack_i;
   logic                        stall_i;

   modport arb (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i, dat_i, ack_i, stall_i,
      output m_dat_o, m_ack_o, m_stall_o, cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
      input  m_dat_o, m_ack_o, m_stall_o
   );

   modport slave (
      input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
      output dat_i, ack_i, stall_i
   );

endinterface

// File: rtl/wb_arbiter_n_pick.sv
// Combinational request picker: lowest index wins, or round-robin starting after 'last'.
module arb_pick #(
   parameter int NMASTER = 2,
   parameter int LW      = (NMASTER > 1) ? $clog2(NMASTER) : 1
) (
   input  logic [NMASTER-1:0] req,
   input  logic [LW-1:0]      last,
   input  logic               mode,
   output logic [NMASTER-1:0] pick
);

   logic found;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      if (mode) begin
         // Walk outward from the slot after the previous owner; d == NMASTER revisits it.
         for (int d = 1; d <= NMASTER; d++) begin
            for (int k = 0; k < NMASTER; k++) begin
               if (!found && req[k] && (k == (int'(last) + d) % NMASTER)) begin
                  pick[k] = 1'b1;
                  found   = 1'b1;
               end
            end
         end
      end else begin
         for (int k = 0; k < NMASTER; k++) begin
            if (!found && req[k]) begin
               pick[k] = 1'b1;
               found   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master Wishbone pipelined arbiter: grant FSM, slave-side mux and outstanding-strobe counter.
module wb_arbiter_n
   import wb_arb_pkg::*;
#(
   parameter int NMASTER = 2,
   parameter int AWIDTH  = 32,
   parameter int DWIDTH  = 32,
   parameter int MODE    = 0,
   parameter int MAXOUT  = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   wb_arbiter_n_if.arb                  bus,
   output arb_state_t                   st,
   output logic [NMASTER-1:0]           gnt,
   output logic [$clog2(MAXOUT+1)-1:0]  cnt
);

   localparam int CW = $clog2(MAXOUT + 1);
   localparam int LW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
   localparam int SW = DWIDTH / 8;
   localparam logic [CW-1:0] CMAX  = CW'(MAXOUT);
   localparam logic [LW-1:0] LAST0 = LW'(NMASTER - 1);

   logic [LW-1:0]      last;
   logic [LW-1:0]      pick_idx;
   logic [NMASTER-1:0] pick;
   logic [NMASTER-1:0] stall_v;
   logic [NMASTER-1:0] ack_v;
   logic [CW-1:0]      cnt_nxt;
   logic               in_grant, g_cyc, g_stb, g_we, accept, retire, full;
   logic [AWIDTH-1:0]  g_adr;
   logic [SW-1:0]      g_sel;
   logic [DWIDTH-1:0]  g_dat;

   arb_pick #(.NMASTER(NMASTER), .LW(LW)) u_pick (
      .req  (bus.m_cyc_i),
      .last (last),
      .mode (MODE == ARB_RR),
      .pick (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int k = 0; k < NMASTER; k++) begin
         if (pick[k]) pick_idx = LW'(k);
      end
   end

   // gnt is one-hot, so at most one master's fields are selected.
   always_comb begin
      g_cyc = 1'b0;
      g_stb = 1'b0;
      g_we  = 1'b0;
      g_adr = '0;
      g_sel = '0;
      g_dat = '0;
      for (int k = 0; k < NMASTER; k++) begin
         if (gnt[k]) begin
            g_cyc = bus.m_cyc_i[k];
            g_stb = bus.m_stb_i[k];
            g_we  = bus.m_we_i[k];
            g_adr = bus.m_adr_i[k*AWIDTH +: AWIDTH];
            g_sel = bus.m_sel_i[k*SW +: SW];
            g_dat = bus.m_dat_i[k*DWIDTH +: DWIDTH];
         end
      end
   end

   assign in_grant = (st == GRANT);
   assign full     = (cnt == CMAX);
   assign accept   = bus.stb_o & ~bus.stall_i;
   assign retire   = bus.ack_i & (cnt != '0);

   // A strobe without cyc is not a valid bus request, so it is never forwarded.
   assign bus.cyc_o   = (st != IDLE);
   assign bus.stb_o   = in_grant & g_cyc & g_stb & ~full;
   assign bus.we_o    = in_grant & g_we;
   assign bus.adr_o   = in_grant ? g_adr : '0;
   assign bus.sel_o   = in_grant ? g_sel : '0;
   assign bus.dat_o   = in_grant ? g_dat : '0;
   assign bus.m_dat_o = bus.dat_i;

   always_comb begin
      stall_v = '1;
      ack_v   = '0;
      for (int k = 0; k < NMASTER; k++) begin
         if (in_grant && gnt[k]) begin
            stall_v[k] = bus.stall_i | full;
            ack_v[k]   = retire;
         end
      end
   end

   assign bus.m_stall_o = stall_v;
   assign bus.m_ack_o   = ack_v;

   always_comb begin
      cnt_nxt = cnt;
      if (accept && !retire)      cnt_nxt = cnt + 1'b1;
      else if (!accept && retire) cnt_nxt = cnt - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         st   <= IDLE;
         gnt  <= '0;
         cnt  <= '0;
         last <= LAST0;
      end else begin
         cnt <= cnt_nxt;
         case (st)
            IDLE: begin
               if (|bus.m_cyc_i) begin
                  gnt  <= pick;
                  last <= pick_idx;
                  st   <= GRANT;
               end
            end
            GRANT: begin
               // Owner released the bus; wait out any acks still owed to it.
               if (!g_cyc) begin
                  if (cnt_nxt == '0) begin
                     st  <= IDLE;
                     gnt <= '0;
                  end else begin
                     st <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (cnt_nxt == '0) begin
                  st  <= IDLE;
                  gnt <= '0;
               end
            end
            default: begin
               st  <= IDLE;
               gnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench: fixed-priority/limit/drain on a 2-master arbiter, round-robin/drain on a 3-master one.
module tb_wb_arbiter_n;
   import wb_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   int   acc;

   always #5 clk = ~clk;

   wb_arbiter_n_if #(.NMASTER(2), .AWIDTH(16), .DWIDTH(16)) bus_a ();
   wb_arbiter_n_if #(.NMASTER(3), .AWIDTH(16), .DWIDTH(16)) bus_b ();

   arb_state_t st_a, st_b;
   logic [1:0] gnt_a, cnt_a;
   logic [2:0] gnt_b, cnt_b;
   logic [3:0] p_req, p_pick;
   logic [1:0] p_last;
   logic       p_mode;

   wb_arbiter_n #(.NMASTER(2), .AWIDTH(16), .DWIDTH(16), .MODE(ARB_FIXED), .MAXOUT(2)) dut_a (
      .clk_i (clk), .rst_i (rst_n), .bus (bus_a), .st (st_a), .gnt (gnt_a), .cnt (cnt_a)
   );

   wb_arbiter_n #(.NMASTER(3), .AWIDTH(16), .DWIDTH(16), .MODE(ARB_RR), .MAXOUT(4)) dut_b (
      .clk_i (clk), .rst_i (rst_n), .bus (bus_b), .st (st_b), .gnt (gnt_b), .cnt (cnt_b)
   );

   arb_pick #(.NMASTER(4)) u_pick (
      .req (p_req), .last (p_last), .mode (p_mode), .pick (p_pick)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic pick_vec(input string tag, input logic md, input logic [3:0] rq,
                           input logic [1:0] ls, input logic [3:0] ep);
      p_mode = md;
      p_req  = rq;
      p_last = ls;
      #1 chk(tag, 32'(p_pick), 32'(ep));
   endtask

   // Called in an IDLE cycle with all requests raised; eg is the expected one-hot grant.
   task automatic b_beat(input logic [2:0] eg, input logic [15:0] ea);
      tick;
      #1;
      chk("rr_gnt", 32'(gnt_b), 32'(eg));
      chk("rr_adr", 32'(bus_b.adr_o), 32'(ea));
      chk("rr_stb", 32'(bus_b.stb_o), 32'd1);
      tick;
      bus_b.m_stb_i = bus_b.m_stb_i & ~eg;
      bus_b.ack_i   = 1'b1;
      #1 chk("rr_ack", 32'(bus_b.m_ack_o), 32'(eg));
      tick;
      bus_b.ack_i   = 1'b0;
      bus_b.m_cyc_i = bus_b.m_cyc_i & ~eg;
      tick;
      #1 chk("rr_idle", 32'(st_b), 32'(IDLE));
      bus_b.m_cyc_i = 3'b111;
      bus_b.m_stb_i = 3'b111;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus_a.m_cyc_i = 2'b11;
      bus_a.m_stb_i = 2'b11;
      bus_a.m_we_i  = 2'b01;
      bus_a.m_adr_i = {16'h2000, 16'h1000};
      bus_a.m_sel_i = {2'b01, 2'b11};
      bus_a.m_dat_i = {16'h5555, 16'hAAAA};
      bus_a.dat_i   = 16'hBEEF;
      bus_a.ack_i   = 1'b1;
      bus_a.stall_i = 1'b0;
      bus_b.m_cyc_i = 3'b000;
      bus_b.m_stb_i = 3'b000;
      bus_b.m_we_i  = 3'b000;
      bus_b.m_adr_i = {16'h0C00, 16'h0B00, 16'h0A00};
      bus_b.m_sel_i = 6'b111111;
      bus_b.m_dat_i = '0;
      bus_b.dat_i   = '0;
      bus_b.ack_i   = 1'b0;
      bus_b.stall_i = 1'b0;

      pick_vec("pick_fix_low",   1'b0, 4'b0110, 2'd3, 4'b0010);
      pick_vec("pick_fix_none",  1'b0, 4'b0000, 2'd0, 4'b0000);
      pick_vec("pick_rr_next",   1'b1, 4'b1001, 2'd0, 4'b1000);
      pick_vec("pick_rr_wrap",   1'b1, 4'b1001, 2'd3, 4'b0001);
      pick_vec("pick_rr_skip",   1'b1, 4'b0101, 2'd2, 4'b0001);
      pick_vec("pick_rr_self",   1'b1, 4'b0100, 2'd2, 4'b0100);

      // Held in reset with both masters requesting.
      tick;
      tick;
      chk("rst_st",    32'(st_a), 32'(IDLE));
      chk("rst_gnt",   32'(gnt_a), 32'd0);
      chk("rst_cnt",   32'(cnt_a), 32'd0);
      chk("rst_cyc",   32'(bus_a.cyc_o), 32'd0);
      chk("rst_stb",   32'(bus_a.stb_o), 32'd0);
      chk("rst_adr",   32'(bus_a.adr_o), 32'd0);
      chk("rst_stall", 32'(bus_a.m_stall_o), 32'h3);
      chk("rst_ack",   32'(bus_a.m_ack_o), 32'd0);
      chk("rst_b_st",  32'(st_b), 32'(IDLE));
      chk("rst_b_stall", 32'(bus_b.m_stall_o), 32'h7);
      bus_a.ack_i = 1'b0;
      rst_n       = 1'b1;

      // Fixed priority: master 0 owns the bus one cycle after reset release.
      tick;
      #1;
      chk("fp_gnt",   32'(gnt_a), 32'h1);
      chk("fp_st",    32'(st_a), 32'(GRANT));
      chk("fp_cyc",   32'(bus_a.cyc_o), 32'd1);
      chk("fp_stb",   32'(bus_a.stb_o), 32'd1);
      chk("fp_adr",   32'(bus_a.adr_o), 32'h1000);
      chk("fp_we",    32'(bus_a.we_o), 32'd1);
      chk("fp_sel",   32'(bus_a.sel_o), 32'h3);
      chk("fp_dat",   32'(bus_a.dat_o), 32'hAAAA);
      chk("fp_mdat",  32'(bus_a.m_dat_o), 32'hBEEF);
      chk("fp_stall", 32'(bus_a.m_stall_o), 32'h2);

      // Four strobe cycles with no acks: only MAXOUT=2 get through.
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus_a.stb_o && !bus_a.stall_i) acc++;
         tick;
      end
      chk("lim_accepts", 32'(acc), 32'd2);
      chk("lim_cnt",     32'(cnt_a), 32'd2);
      chk("lim_stb",     32'(bus_a.stb_o), 32'd0);
      chk("lim_stall",   32'(bus_a.m_stall_o), 32'h3);
      bus_a.ack_i = 1'b1;
      #1;
      chk("lim_ack",     32'(bus_a.m_ack_o), 32'h1);
      tick;
      bus_a.ack_i = 1'b0;
      #1;
      chk("lim_cnt_dec", 32'(cnt_a), 32'd1);
      chk("lim_third",   32'(bus_a.stb_o), 32'd1);
      chk("lim_unstall", 32'(bus_a.m_stall_o), 32'h2);
      tick;
      bus_a.ack_i = 1'b1;
      tick;
      #1;
      chk("sim_pre_cnt", 32'(cnt_a), 32'd1);
      chk("sim_stb",     32'(bus_a.stb_o), 32'd1);
      chk("sim_ack",     32'(bus_a.m_ack_o), 32'h1);
      tick;
      chk("sim_cnt",     32'(cnt_a), 32'd1);

      // Slave stall blocks acceptance even with room in the counter.
      bus_a.ack_i   = 1'b0;
      bus_a.stall_i = 1'b1;
      #1;
      chk("stl_stb",   32'(bus_a.stb_o), 32'd1);
      chk("stl_stall", 32'(bus_a.m_stall_o), 32'h3);
      tick;
      chk("stl_cnt",   32'(cnt_a), 32'd1);

      // Master 0 drops cyc with one strobe outstanding.
      bus_a.stall_i = 1'b0;
      bus_a.m_cyc_i = 2'b10;
      bus_a.m_stb_i = 2'b00;
      tick;
      chk("dra_st",    32'(st_a), 32'(DRAIN));
      chk("dra_cyc",   32'(bus_a.cyc_o), 32'd1);
      chk("dra_stb",   32'(bus_a.stb_o), 32'd0);
      chk("dra_stall", 32'(bus_a.m_stall_o), 32'h3);
      bus_a.ack_i = 1'b1;
      #1 chk("dra_ack", 32'(bus_a.m_ack_o), 32'd0);
      tick;
      bus_a.ack_i = 1'b0;
      #1;
      chk("dra_idle",  32'(st_a), 32'(IDLE));
      chk("dra_cyc0",  32'(bus_a.cyc_o), 32'd0);
      chk("dra_adr0",  32'(bus_a.adr_o), 32'd0);
      tick;
      #1;
      chk("m1_gnt",   32'(gnt_a), 32'h2);
      chk("m1_adr",   32'(bus_a.adr_o), 32'h2000);
      chk("m1_sel",   32'(bus_a.sel_o), 32'h1);
      chk("m1_we",    32'(bus_a.we_o), 32'd0);
      chk("m1_dat",   32'(bus_a.dat_o), 32'h5555);
      chk("m1_stall", 32'(bus_a.m_stall_o), 32'h1);

      // Release with nothing outstanding, then a spurious ack while idle.
      bus_a.m_cyc_i = 2'b00;
      tick;
      chk("rel_idle", 32'(st_a), 32'(IDLE));
      bus_a.ack_i = 1'b1;
      #1 chk("spur_ack", 32'(bus_a.m_ack_o), 32'd0);
      tick;
      bus_a.ack_i = 1'b0;
      #1;
      chk("spur_cnt", 32'(cnt_a), 32'd0);
      chk("spur_st",  32'(st_a), 32'(IDLE));

      // Round-robin with every master requesting: 0, 1, 2, 0.
      bus_b.m_cyc_i = 3'b111;
      bus_b.m_stb_i = 3'b111;
      b_beat(3'b001, 16'h0A00);
      b_beat(3'b010, 16'h0B00);
      b_beat(3'b100, 16'h0C00);
      b_beat(3'b001, 16'h0A00);

      // Drain: master 0 alone, three strobes, then drops cyc while master 1 waits.
      bus_b.m_cyc_i = 3'b001;
      bus_b.m_stb_i = 3'b001;
      tick;
      #1 chk("bdr_gnt", 32'(gnt_b), 32'h1);
      tick;
      tick;
      tick;
      bus_b.m_stb_i = 3'b000;
      bus_b.m_cyc_i = 3'b010;
      #1 chk("bdr_cnt3", 32'(cnt_b), 32'd3);
      tick;
      #1;
      chk("bdr_st",    32'(st_b), 32'(DRAIN));
      chk("bdr_cyc",   32'(bus_b.cyc_o), 32'd1);
      chk("bdr_stb",   32'(bus_b.stb_o), 32'd0);
      chk("bdr_stall", 32'(bus_b.m_stall_o), 32'h7);
      for (int i = 0; i < 3; i++) begin
         bus_b.ack_i = 1'b1;
         #1;
         chk("bdr_in_drain", 32'(st_b), 32'(DRAIN));
         chk("bdr_ack",      32'(bus_b.m_ack_o), 32'd0);
         tick;
      end
      bus_b.ack_i = 1'b0;
      #1;
      chk("bdr_idle", 32'(st_b), 32'(IDLE));
      chk("bdr_cnt0", 32'(cnt_b), 32'd0);
      chk("bdr_cyc0", 32'(bus_b.cyc_o), 32'd0);
      tick;
      #1;
      chk("bdr_next_gnt", 32'(gnt_b), 32'h2);
      chk("bdr_next_st",  32'(st_b), 32'(GRANT));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_n.md
# wb_arbiter_n

Parametrised N-master Wishbone pipelined bus arbiter. It is the successor to the fixed two-master instruction/data arbiter in the bexkat1 pipeline. It adds the following:
- configurable master count and widths;
- selectable fixed-priority or round-robin policy;
- an outstanding-transaction counter with a configurable limit;
- a drain state that lets a master drop `cyc` safely with acks still in flight.

It sits between the CPU's bus masters (ifetch, mem, future DMA) and the single system Wishbone slave port.

## Interface
Parameters:
- `NMASTER`, 2, number of masters; index 0 is highest fixed priority.
- `AWIDTH`, 32, address width.
- `DWIDTH`, 32, data width; must be a multiple of 8.
- `MODE`, 0, 0 = fixed priority, 1 = round-robin.
- `MAXOUT`, 4, maximum accepted-but-unacked strobes per grant (≥1).

Ports:
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `m_cyc_i` in NMASTER: per-master cycle.
- `m_stb_i` in NMASTER: per-master strobe.
- `m_we_i` in NMASTER: per-master write enable.
- `m_adr_i` in NMASTER*AWIDTH: packed addresses; master k at [k*AWIDTH +: AWIDTH].
- `m_sel_i` in NMASTER*DWIDTH/8: packed byte selects.
- `m_dat_i` in NMASTER*DWIDTH: packed write data.
- `m_dat_o` out DWIDTH: read data, broadcast (= `dat_i`).
- `m_ack_o` out NMASTER: ack, granted master only.
- `m_stall_o` out NMASTER: stall per master.
- `cyc_o`, `stb_o`, `we_o` out 1: slave-side controls.
- `adr_o` out AWIDTH; `sel_o` out DWIDTH/8; `dat_o` out DWIDTH: slave-side data path.
- `dat_i` in DWIDTH; `ack_i` in 1; `stall_i` in 1: slave responses.

## Operation
- State machine (`st`): IDLE, GRANT, DRAIN.
- IDLE:
  - If any `m_cyc_i` is set, the picked master is registered into `gnt` (one-hot) → GRANT.
  - Otherwise stay in IDLE.
- Pick policy:
  - MODE 0: lowest set index wins.
  - MODE 1: first set index strictly after `last` (wrapping), where `last` is the index of the most recent grant; `last` resets to NMASTER-1.
- GRANT:
  - `cyc_o`=1.
  - Slave outputs are muxed from the granted master.
  - `stb_o` = `m_stb_i[g]` & (`cnt` < MAXOUT).
  - `m_stall_o[g]` = `stall_i` | (`cnt` == MAXOUT).
  - `m_ack_o[g]` = `ack_i` (combinational).
  - If `m_cyc_i[g]` falls: `cnt`==0 → IDLE; otherwise → DRAIN.
- DRAIN:
  - `cyc_o` stays 1, `stb_o`=0.
  - `ack_i` decrements `cnt` but is not routed to any master.
  - `cnt` reaches 0 → IDLE.
- Outstanding counter `cnt`, width $clog2(MAXOUT+1):
  - +1 on `stb_o` & !`stall_i`.
  - −1 on `ack_i` & `cnt`≠0.
  - Both in the same cycle → unchanged.
  - `ack_i` with `cnt`==0 is ignored; not routed, no underflow.
- Ungranted masters: `m_stall_o`=1, `m_ack_o`=0, in every state.
- In IDLE, all `m_stall_o`=1 and slave outputs are 0.
- A master that raises `cyc` during another's grant waits. No preemption; the grant ends only via `m_cyc_i[g]` low.
- Reset mid-transfer: all state is cleared immediately and in-flight acks are lost; masters must be reset concurrently.

## Timing
- Reset values:
  - `st`=IDLE, `gnt`=0, `cnt`=0, `last`=NMASTER-1.
  - `cyc_o`=`stb_o`=`we_o`=0; `adr_o`/`sel_o`/`dat_o`=0.
  - `m_ack_o`=0, `m_stall_o`=all 1.
- Grant latency: `m_cyc_i` high in cycle 0 → `cyc_o`/`stb_o` valid in cycle 1.
- Back-to-back strobes: one per cycle while `stall_i`=0 and `cnt`<MAXOUT.
- Ack path is zero latency (combinational `ack_i` → `m_ack_o`).
- Release:
  - `m_cyc_i[g]` low in cycle n with `cnt`=0 → IDLE at n+1.
  - A new grant can be issued at n+2 at the earliest (one idle cycle between owners).

## Structure
- Package `wb_arb_pkg`:
  - `arb_state_t` enum {IDLE, GRANT, DRAIN};
  - constants `ARB_FIXED`=0, `ARB_RR`=1.
- Sub-module `arb_pick`: combinational, parametrised NMASTER. Inputs: request vector, `last` index, mode. Output: one-hot pick. It is instantiated once and tested standalone.
- The muxes and the counter live in the top.

## Test plan
- Reset: `rst_i`=0 with `m_cyc_i`=2'b11 → `cyc_o`=0, `m_stall_o`=2'b11; release reset → master 0 granted next cycle in MODE 0.
- Round-robin: MODE 1, NMASTER=3, all cyc high, each master does one single-beat access → grant order 0,1,2,0.
- Outstanding limit: MAXOUT=2, slave never acks, master 0 strobes 4 times → exactly 2 `stb_o` accepts, then `m_stall_o[0]`=1; one `ack_i` → third accept next cycle.
- Drain: 3 strobes accepted, master drops `cyc` → DRAIN; 3 `ack_i` give `m_ack_o`=0; IDLE after the third ack; master 1 granted after it.
- Simultaneous accept+ack at `cnt`=1 → `cnt` stays 1; spurious `ack_i` in IDLE → `m_ack_o`=0, `cnt` stays 0.
